// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with TX FIFO (optional parity: UART_TX_PARITY_EN)
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  byte_en,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        txd
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_V  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] TXDATA_A = BASE_ADDR;
    localparam logic [31:0] STATUS_A = BASE_ADDR + 32'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        txd_q, txd_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic        txdata_wr, status_wr;
    logic        push, pop, ovf_event;
    logic        empty, full, busy, bit_end;
    logic [AW:0] count;
    logic [8:0]  count_ext;
    logic [7:0]  head;
    logic [31:0] status;
    logic        unused_bits;

    // Register decode, FIFO flags and the head-of-queue byte
    always_comb begin
        txdata_wr = wr_en && (wr_addr == TXDATA_A) && byte_en[0];
        status_wr = wr_en && (wr_addr == STATUS_A) && byte_en[0];
        count     = wr_ptr_q - rd_ptr_q;
        count_ext = 9'(count);
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (count == DEPTH_V);
        head      = mem_q[rd_ptr_q[AW-1:0]];
        busy      = (state_q != IDLE);
        bit_end   = (bit_cnt_q == BIT_LAST);
    end

    // Frame sequencer: decides next state, next txd level and when to pop the FIFO
    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        bit_cnt_d = bit_cnt_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                bit_cnt_d = 16'd0;
                txd_d     = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    txd_d   = 1'b0;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 16'd0;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = 16'd0;
                    txd_d     = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d = 16'd0;
                    if (!empty) begin
                        // Chain straight into the next start bit
                        pop     = 1'b1;
                        state_d = START;
                        txd_d   = 1'b0;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                txd_d     = 1'b1;
                bit_cnt_d = 16'd0;
            end
        endcase
    end

    // FIFO pointer and sticky overflow update; a pop frees the slot for a same-cycle push
    always_comb begin
        push      = txdata_wr && (!full || pop);
        ovf_event = txdata_wr && full && !pop;
        ovf_d     = ovf_event || (ovf_q && !(status_wr && wr_data[3]));
        wr_ptr_d  = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d  = rd_ptr_q + (AW + 1)'(pop);
    end

    // Sequencer, FIFO pointer and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            txd_q     <= 1'b1;
            bit_cnt_q <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data[7:0];
        end
    end

    // Load path: STATUS is live, TXDATA and unmapped addresses read as zero
    always_comb begin
        status  = {16'b0, count_ext[7:0], 4'b0, ovf_q, empty, full, busy};
        rd_data = (rd_addr == STATUS_A) ? status : 32'd0;
    end

    assign txd         = txd_q;
    assign unused_bits = ^{wr_data[31:8], byte_en[3:1], count_ext[8]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam logic [31:0] TXDATA_A = BASE;
    localparam logic [31:0] STATUS_A = BASE + 32'd4;
    localparam int          CPB      = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  byte_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        txd;

    int errors = 0;
    int checks = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .byte_en (byte_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .txd     (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level at bit-time i of a frame carrying byte b
    function automatic logic exp_bit(input logic [7:0] b, input logic par, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && FRAME_BITS == 11) return par;
        return 1'b1;
    endfunction

    // One-cycle store; entered and left on a falling edge
    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        byte_en = be;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = 32'd0;
        wr_data = 32'd0;
        byte_en = 4'd0;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 32'd0;
        wr_data = 32'd0;
        byte_en = 4'd0;
        rd_addr = STATUS_A;
        repeat (2) @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++;
        if (rd_data !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h expected 00000004", rd_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || rd_data !== 32'h0000_0004) begin
            errors++; $display("FAIL post_reset_idle: got txd=%b status=%h expected txd=1 status=00000004", txd, rd_data);
        end
        rd_addr = TXDATA_A;
        #1;
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL txdata_read: got %h expected 00000000", rd_data); end
        rd_addr = STATUS_A;
    endtask

    task automatic test_single_frame;
        int bad_txd;
        int bad_busy;
        bad_txd  = 0;
        bad_busy = 0;
        store(TXDATA_A, 32'h0000_0055, 4'b0001);
        checks++;
        if (txd !== 1'b1 || rd_data !== 32'h0000_0100) begin
            errors++; $display("FAIL single_queued: got txd=%b status=%h expected txd=1 status=00000100", txd, rd_data);
        end
        for (int i = 0; i < FRAME_BITS * CPB; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (rd_data !== 32'h0000_0005) begin errors++; $display("FAIL single_start_status: got %h expected 00000005", rd_data); end
            end
            if (txd !== exp_bit(8'h55, 1'b0, i / CPB)) bad_txd++;
            if (rd_data[0] !== 1'b1) bad_busy++;
        end
        checks++;
        if (bad_txd != 0) begin errors++; $display("FAIL single_frame_bits: got %0d wrong cycles expected 0", bad_txd); end
        checks++;
        if (bad_busy != 0) begin errors++; $display("FAIL single_busy_len: got %0d idle cycles in frame expected 0", bad_busy); end
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || rd_data !== 32'h0000_0004) begin
            errors++; $display("FAIL single_end: got txd=%b status=%h expected txd=1 status=00000004", txd, rd_data);
        end
    endtask

    task automatic test_back_to_back;
        int         bad;
        logic [7:0] b;
        bad = 0;
        store(TXDATA_A, 32'h0000_00A5, 4'b0001);
        store(TXDATA_A, 32'h0000_003C, 4'b0001);
        checks++;
        if (rd_data !== 32'h0000_0101 || txd !== 1'b0) begin
            errors++; $display("FAIL b2b_first_start: got txd=%b status=%h expected txd=0 status=00000101", txd, rd_data);
        end
        for (int i = 0; i < 2 * FRAME_BITS * CPB; i++) begin
            if (i > 0) @(negedge clk);
            b = (i < FRAME_BITS * CPB) ? 8'hA5 : 8'h3C;
            if (txd !== exp_bit(b, 1'b0, (i / CPB) % FRAME_BITS)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL b2b_frames: got %0d wrong cycles expected 0", bad); end
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || rd_data !== 32'h0000_0004) begin
            errors++; $display("FAIL b2b_end: got txd=%b status=%h expected txd=1 status=00000004", txd, rd_data);
        end
    endtask

    task automatic test_overflow;
        int n;
        for (int k = 0; k < 10; k++) store(TXDATA_A, 32'h10 + k, 4'b0001);
        checks++;
        if (rd_data !== 32'h0000_080B) begin errors++; $display("FAIL ovf_status: got %h expected 0000080b", rd_data); end
        store(STATUS_A, 32'h0000_0008, 4'b0001);
        checks++;
        if (rd_data !== 32'h0000_0803) begin errors++; $display("FAIL ovf_clear: got %h expected 00000803", rd_data); end
        repeat (FRAME_BITS * CPB - 10) @(negedge clk);
        store(TXDATA_A, 32'h0000_0077, 4'b0001);
        checks++;
        if (rd_data !== 32'h0000_0803) begin errors++; $display("FAIL push_on_pop_full: got %h expected 00000803", rd_data); end
        n = 0;
        while (rd_data !== 32'h0000_0004 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin errors++; $display("FAIL ovf_drain: got status=%h after %0d cycles expected 00000004", rd_data, n); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] bytes [2];
        logic       pars  [2];
        int         bad;
        bytes[0] = 8'h07; pars[0] = 1'b1;
        bytes[1] = 8'h03; pars[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            bad = 0;
            store(TXDATA_A, {24'd0, bytes[t]}, 4'b0001);
            for (int i = 0; i < FRAME_BITS * CPB; i++) begin
                @(negedge clk);
                if (txd !== exp_bit(bytes[t], pars[t], i / CPB)) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL parity_frame_%0d: got %0d wrong cycles expected 0", t, bad); end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_reset_mid_frame;
        int bad;
        bad = 0;
        store(TXDATA_A, 32'h0000_005A, 4'b0001);
        repeat (14) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL mid_data_bit2: got %b expected 0", txd); end
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = TXDATA_A;
        wr_data = 32'h0000_00FF;
        byte_en = 4'b0001;
        @(negedge clk);
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        byte_en = 4'd0;
        checks++;
        if (txd !== 1'b1 || rd_data !== 32'h0000_0004) begin
            errors++; $display("FAIL reset_abort: got txd=%b status=%h expected txd=1 status=00000004", txd, rd_data);
        end
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1 || rd_data !== 32'h0000_0004) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL no_frame_after_reset: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_ignored_stores;
        int bad;
        bad = 0;
        store(TXDATA_A, 32'h0000_0041, 4'b0010);
        store(BASE + 32'd8, 32'h0000_0041, 4'b0001);
        checks++;
        if (rd_data !== 32'h0000_0004) begin errors++; $display("FAIL ignored_status: got %h expected 00000004", rd_data); end
        repeat (8) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ignored_txd: got %0d low cycles expected 0", bad); end
        rd_addr = BASE + 32'd8;
        #1;
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h expected 00000000", rd_data); end
        rd_addr = STATUS_A;
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_overflow;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_reset_mid_frame;
        test_ignored_stores;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: word-aligned base of the register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries, power of two, 2..256.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  store strobe from core.
REQ-007 SHALL have port wr_addr  input  32  store address.
REQ-008 SHALL have port wr_data  input  32  store data.
REQ-009 SHALL have port byte_en  input  4  store byte lanes.
REQ-010 SHALL have port rd_addr  input  32  load address, driven from core data-read address.
REQ-011 SHALL have port rd_data  output  32  load data, combinational from rd_addr and current state.
REQ-012 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-013 SHALL decode TXDATA at BASE_ADDR and STATUS at BASE_ADDR+4; other addresses ignored on write and read as 0.
REQ-014 SHALL push wr_data[7:0] into the FIFO when wr_en=1, wr_addr=TXDATA, byte_en[0]=1 and FIFO not full; byte_en[0]=0 -> no push.
REQ-015 SHALL, on a TXDATA push while full, drop the byte and set sticky overflow; a push in the same cycle as a pop while full SHALL be accepted.
REQ-016 SHALL clear overflow on a STATUS write with byte_en[0]=1 and wr_data[3]=1; a clear and a new overflow in the same cycle SHALL leave overflow set.
REQ-017 SHALL return STATUS as {16'b0, count[7:0], 4'b0, overflow, empty, full, busy}: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow, bits[15:8] FIFO occupancy.
REQ-018 SHALL return 0 on reads of TXDATA.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 SHALL, in IDLE with FIFO non-empty, pop the head byte into a shift register and enter START on the next edge.
REQ-021 SHALL drive txd=0 in START, data bits LSB first in DATA, 1 in STOP, 1 in IDLE; each bit held exactly CLKS_PER_BIT cycles, timed by a bit counter reloaded on every state/bit change.
REQ-022 SHALL leave DATA after 8 bits, entering PARITY if UART_TX_PARITY_EN is defined, else STOP.
REQ-023 SHALL, at end of STOP, pop and enter START directly if FIFO non-empty (back-to-back frames, no idle cycle), else enter IDLE.
REQ-024 SHALL have latency of exactly 1 cycle from an accepted push into an empty FIFO with FSM idle to txd falling.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, with full/empty derived from an extra pointer bit or an occupancy counter.
REQ-026 SHALL register txd (no combinational path from any input to txd).

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge: FSM IDLE, txd=1, FIFO empty (count 0), overflow 0, bit counter 0, shift register 0.
REQ-028 SHALL abort any frame in progress on reset, with txd high from the first edge with rst_n=0; stores during reset ignored.

Configuration
REQ-029 SHALL, with macro UART_TX_PARITY_EN defined, insert one even-parity bit (XOR of 8 data bits) after DATA, held CLKS_PER_BIT cycles; frame = 11 bit-times.
REQ-030 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely; frame = 10 bit-times.

Verification
REQ-031 SHALL cover: CLKS_PER_BIT=4, store 0x55 to TXDATA -> txd 0 for 4 cycles, then 1,0,1,0,1,0,1,0, then 1 for 4 cycles; busy=1 for 40 cycles.
REQ-032 SHALL cover: store 0xA5 and 0x3C back-to-back -> second start bit immediately follows first stop bit, no idle cycle.
REQ-033 SHALL cover: FIFO_DEPTH=8, 10 stores while FSM stalled on first frame -> 1 popped, 8 buffered, 1 dropped; STATUS reads full=1, overflow=1, count=8; STATUS write 0x8 -> overflow=0.
REQ-034 SHALL cover: UART_TX_PARITY_EN defined, store 0x07 -> parity bit 1; store 0x03 -> parity bit 0.
REQ-035 SHALL cover: rst_n low for 1 cycle mid-DATA -> txd=1, STATUS=0x0000_0004 next cycle, no further frame.
REQ-036 SHALL cover: store with byte_en=4'b0010 to TXDATA and store to BASE_ADDR+8 -> no push, STATUS unchanged.
